adc_fifo_drain: RTL and testbench

- Downstream consumer of the multi-channel ADC capture block.
- Drains the per-channel sample FIFOs round-robin through the shared address/read-enable/muxed-data interface.
- Tags each 12-bit sample with channel ID and a per-channel sequence count, then presents 32-bit words on a valid/ready stream toward the AXI-side buffer.
- Also records sticky per-channel FIFO-full (overflow) flags.

---
 rtl/adc_fifo_drain.sv | 123 ++++++++++++
 tb/tb_adc_fifo_drain.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_fifo_drain.sv
// adc_fifo_drain: round-robin drain of per-channel ADC FIFOs into tagged 32-bit stream words.
// Optional ADC_DRAIN_CH_MASK_EN adds a ch_mask input; masked channels are skipped like empty ones.
module adc_fifo_drain #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int BURST_LEN    = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            enable,
`ifdef ADC_DRAIN_CH_MASK_EN
    input  logic [NUM_CHANNELS-1:0]         ch_mask,
`endif
    output logic [$clog2(NUM_CHANNELS)-1:0] fifo_addr,
    output logic [NUM_CHANNELS-1:0]         fifo_rd_en,
    input  logic                            fifo_not_empty,
    input  logic                            fifo_full,
    input  logic [DATA_WIDTH-1:0]           fifo_dout,
    output logic [31:0]                     m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_CHANNELS-1:0]         overflow_flags,
    input  logic [NUM_CHANNELS-1:0]         overflow_clr,
    output logic                            busy
);
    localparam int PW = $clog2(NUM_CHANNELS);
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {IDLE, CHECK, READ, WAIT, OUT} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d, addr_q, addr_d, ptr_nxt;
    logic [BW-1:0]           burst_q, burst_d;
    logic [15:0]             seq_q [NUM_CHANNELS];
    logic [15:0]             seq_d [NUM_CHANNELS];
    logic [31:0]             m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic [NUM_CHANNELS-1:0] ovf_q, ovf_d, ptr_sel, addr_sel;
    logic                    ch_ok;

`ifdef ADC_DRAIN_CH_MASK_EN
    assign ch_ok = ch_mask[ptr_q];
`else
    assign ch_ok = 1'b1;
`endif

    assign ptr_nxt        = (ptr_q == PW'(NUM_CHANNELS - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_sel        = NUM_CHANNELS'(1) << ptr_q;
    assign addr_sel       = NUM_CHANNELS'(1) << addr_q;
    assign fifo_addr      = addr_q;
    assign m_data         = m_data_q;
    assign m_valid        = m_valid_q;
    assign overflow_flags = ovf_q;
    assign busy           = state_q != IDLE;

    // Next-state, pointer/burst/sequence bookkeeping, read strobe and output word capture.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        burst_d    = burst_q;
        seq_d      = seq_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        fifo_rd_en = '0;
        case (state_q)
            IDLE: state_d = enable ? CHECK : IDLE;
            CHECK: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (fifo_not_empty && ch_ok) begin
                    state_d = READ;
                end else begin
                    ptr_d   = ptr_nxt;
                    burst_d = '0;
                end
            end
            READ: begin
                fifo_rd_en = fifo_not_empty ? ptr_sel : '0;
                state_d    = WAIT;
            end
            WAIT: begin
                m_data_d  = {seq_q[ptr_q], 4'(ptr_q), 12'(fifo_dout)};
                m_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    seq_d[ptr_q] = seq_q[ptr_q] + 16'd1;
                    m_valid_d    = 1'b0;
                    state_d      = enable ? CHECK : IDLE;
                    ptr_d        = (burst_q == BW'(BURST_LEN - 1)) ? ptr_nxt : ptr_q;
                    burst_d      = (burst_q == BW'(BURST_LEN - 1)) ? '0 : burst_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        addr_d = (state_d == IDLE) ? addr_q : ptr_d;
        ovf_d  = (ovf_q & ~overflow_clr) | (fifo_full ? addr_sel : '0);
    end

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            addr_q    <= '0;
            burst_q   <= '0;
            seq_q     <= '{default: '0};
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            burst_q   <= burst_d;
            seq_q     <= seq_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule

// File: tb/tb_adc_fifo_drain.sv
// tb_adc_fifo_drain: directed and randomized checks of adc_fifo_drain against queue-based FIFO and word models.
module tb_adc_fifo_drain;
    localparam int N  = 4;
    localparam int DW = 12;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    fifo_addr;
    logic [N-1:0]  fifo_rd_en;
    logic          fifo_not_empty, fifo_full;
    logic [DW-1:0] dout = '0;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [N-1:0]  overflow_flags;
    logic [N-1:0]  overflow_clr = '0;
    logic          busy;
    logic [N-1:0]  full_vec = '0;

    logic [11:0]   fq   [N][$];
    logic [11:0]   expq [N][$];
    int            cnt  [N];
    int            seq_m[N];
    logic [31:0]   got[$];
    int            n_chk = 0, n_fail = 0, cyc = 0, last_rd = -10;
    logic          pv = 1'b0, pr = 1'b0;
    logic [31:0]   pd = '0;
    logic [N-1:0]  ov_m = '0;

    always #5 clk = ~clk;

    assign fifo_not_empty = cnt[fifo_addr] != 0;
    assign fifo_full      = full_vec[fifo_addr];

    adc_fifo_drain #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rstn(rstn), .enable(enable),
`ifdef ADC_DRAIN_CH_MASK_EN
        .ch_mask({N{1'b1}}),
`endif
        .fifo_addr(fifo_addr), .fifo_rd_en(fifo_rd_en), .fifo_not_empty(fifo_not_empty),
        .fifo_full(fifo_full), .fifo_dout(dout), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .overflow_flags(overflow_flags), .overflow_clr(overflow_clr), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [11:0] v);
        fq[c].push_back(v);
        expq[c].push_back(v);
        cnt[c]++;
    endtask

    function automatic int pending();
        int s = 0;
        for (int c = 0; c < N; c++) s += expq[c].size();
        return s;
    endfunction

    // One clock: protocol/scoreboard checks at negedge, FIFO model read response just after posedge.
    task automatic cycle();
        logic [N-1:0] rd, sel;
        int           c;
        @(negedge clk);
        rd = fifo_rd_en;
        if (!rstn) begin
            ov_m = '0;
            pv   = 1'b0;
            rd   = '0;
        end else begin
            chk("ovf_flags", overflow_flags, ov_m);
            if (|fifo_rd_en) begin
                sel = N'(1) << fifo_addr;
                chk("rd_onehot", fifo_rd_en, sel);
                chk("rd_nonempty", fifo_not_empty, 1);
                last_rd = cyc;
            end
            if (m_valid && !pv) chk("latency", cyc - last_rd, 2);
            if (pv && !pr) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, pd);
            end
            if (m_valid && m_ready) begin
                c = int'(m_data[15:12]);
                chk("chan_range", c < N, 1);
                if (c < N) begin
                    chk("word_expected", expq[c].size() != 0, 1);
                    if (expq[c].size() != 0) chk("sample", m_data[11:0], expq[c].pop_front());
                    chk("seq", m_data[31:16], 16'(seq_m[c]));
                    seq_m[c]++;
                end
                got.push_back(m_data);
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            sel = N'(1) << fifo_addr;
            ov_m = (ov_m & ~overflow_clr) | (full_vec[fifo_addr] ? sel : '0);
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (rd[i] && fq[i].size() != 0) begin
                dout = fq[i].pop_front();
                cnt[i]--;
            end
    endtask

    task automatic clear_model();
        for (int c = 0; c < N; c++) begin
            fq[c].delete();
            expq[c].delete();
            cnt[c]   = 0;
            seq_m[c] = 0;
        end
        got.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        enable = 1'b0;
        m_ready = 1'b0;
        full_vec = '0;
        overflow_clr = '0;
        clear_model();
        cycle();
        cycle();
        rstn = 1'b1;
    endtask

    task automatic wait_words(input int n);
        int b = 0;
        while (got.size() < n && b < 600) begin
            cycle();
            b++;
        end
        chk("word_count", got.size(), n);
    endtask

    task automatic wait_valid();
        int b = 0;
        while (!m_valid && b < 60) begin
            cycle();
            b++;
        end
        chk("valid_seen", m_valid, 1);
    endtask

    initial begin
        logic [11:0] s0 [10];
        logic [11:0] s1, a, y;
        logic [31:0] expw [11];
        logic [31:0] held;
        int          n0, b;

        // Reset values
        clear_model();
        #2;
        chk("rst_valid", m_valid, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_ovf", overflow_flags, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", m_data, 0);
        chk("rst_addr", fifo_addr, 0);
        do_reset();

        // All FIFOs empty: pointer scans, no reads
        enable = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            chk("scan_addr", fifo_addr, i % N);
            chk("scan_busy", busy, 1);
            chk("scan_valid", m_valid, 0);
            chk("scan_rd", fifo_rd_en, 0);
            cycle();
        end
        enable = 1'b0;
        cycle();
        chk("idle_busy", busy, 0);

        // Two samples in channel 2
        push(2, 12'hABC);
        push(2, 12'h123);
        m_ready = 1'b1;
        enable = 1'b1;
        wait_words(2);
        chk("ch2_w0", got[0], 32'h0000_2ABC);
        chk("ch2_w1", got[1], 32'h0001_2123);

        // Burst limit: ch0 ten samples, ch1 one sample
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s0[i] = 12'($urandom_range(0, 4095));
            push(0, s0[i]);
        end
        s1 = 12'($urandom_range(0, 4095));
        push(1, s1);
        for (int i = 0; i < BL; i++) expw[i] = {16'(i), 4'd0, s0[i]};
        expw[8]  = {16'd0, 4'd1, s1};
        expw[9]  = {16'd8, 4'd0, s0[8]};
        expw[10] = {16'd9, 4'd0, s0[9]};
        m_ready = 1'b1;
        enable = 1'b1;
        wait_words(11);
        for (int i = 0; i < 11; i++) chk($sformatf("burst_w%0d", i), got[i], expw[i]);

        // Back-pressure while a word is presented
        got.delete();
        m_ready = 1'b0;
        a = 12'($urandom_range(0, 4095));
        push(3, a);
        push(3, 12'h5A5);
        wait_valid();
        held = m_data;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_valid", m_valid, 1);
            chk("bp_data", m_data, held);
            chk("bp_rd", fifo_rd_en, 0);
        end
        m_ready = 1'b1;
        cycle();
        chk("bp_one_word", got.size(), 1);
        chk("bp_word", got[0], {16'd0, 4'd3, a});
        wait_words(2);

        // Overflow flag: set wins over simultaneous clear, clear alone empties it
        b = 0;
        while (fifo_addr != 2'd3 && b < 20) begin
            cycle();
            b++;
        end
        chk("ovf_addr", fifo_addr, 3);
        enable = 1'b0;
        cycle();
        chk("ovf_idle_addr", fifo_addr, 3);
        full_vec = 4'b1000;
        overflow_clr = 4'b1000;
        cycle();
        full_vec = '0;
        overflow_clr = '0;
        chk("ovf_set_wins", overflow_flags, 4'b1000);
        cycle();
        cycle();
        overflow_clr = 4'b1000;
        cycle();
        overflow_clr = '0;
        chk("ovf_cleared", overflow_flags, 4'b0000);

        // Reset while a word is waiting in OUT
        push(0, 12'h777);
        m_ready = 1'b0;
        enable = 1'b1;
        wait_valid();
        full_vec = '1;
        cycle();
        full_vec = '0;
        cycle();
        rstn = 1'b0;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_rd", fifo_rd_en, 0);
        chk("arst_ovf", overflow_flags, 0);
        chk("arst_busy", busy, 0);
        do_reset();
        y = 12'($urandom_range(0, 4095));
        push(0, y);
        m_ready = 1'b1;
        enable = 1'b1;
        wait_words(1);
        chk("arst_first_word", got[0], {16'd0, 4'd0, y});

        // Randomized traffic, back-pressure, enable drops and overflow activity
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) push($urandom_range(0, N - 1), 12'($urandom_range(0, 4095)));
            m_ready = $urandom_range(0, 3) != 0;
            enable = $urandom_range(0, 7) != 0;
            full_vec = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
            overflow_clr = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0;
            cycle();
        end
        m_ready = 1'b1;
        enable = 1'b1;
        full_vec = '0;
        overflow_clr = '0;
        b = 0;
        while (pending() != 0 && b < 3000) begin
            cycle();
            b++;
        end
        chk("rand_drained", pending(), 0);
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
